prop_sequencer: RTL and testbench

//  Training-step scheduler for a stack of LAYERS perceptron-unit layers. Per sample: accepts input via

---
 rtl/prop_seq_pkg.sv | 23 ++
 rtl/prop_sequencer.sv | 176 +++++++++++++++++
 tb/tb_prop_sequencer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prop_seq_pkg.sv
// ---------------------------------------------------------------------------
// prop_seq_pkg
//   Shared types for the perceptron training-step sequencer.
//   - seq_state_t : sequencer FSM states
//   - idx_width() : width of the layer index; never zero, so a one-layer
//                   stack still gets a legal 1-bit index
// ---------------------------------------------------------------------------
package prop_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SAMPLE,
        FWD,
        BWD,
        NEXT,
        DONE
    } seq_state_t;

    function automatic int idx_width(input int layers);
        return (layers > 1) ? $clog2(layers) : 1;
    endfunction

endpackage

// File: rtl/prop_sequencer.sv
// ---------------------------------------------------------------------------
// prop_sequencer
//   Training-step scheduler for a stack of LAYERS perceptron-unit layers.
//   For each sample of a batch it accepts the sample through a valid/ready
//   handshake, strobes fd_prop one layer per cycle from layer 0 upward, then
//   (train mode only) strobes bk_prop one layer per cycle from the top layer
//   down, and finally toggles the shared oscillator phase.
//
// Ports
//   clk_in            in   system clock
//   rst_in            in   asynchronous reset, active low
//   start_in          in   begin a batch (sampled only while idle)
//   train_in          in   1 = forward+backward, 0 = forward only (latched at start)
//   num_samples_in    in   batch length N (latched at start)
//   abort_in          in   cancel the running batch
//   sample_valid_in   in   source presents a sample/label
//   sample_ready_out  out  sequencer waiting for a sample
//   fd_prop_out       out  one-hot forward strobe, bit k = layer k
//   bk_prop_out       out  one-hot backward strobe
//   oscillator_out    out  shared oscillator phase
//   busy_out          out  batch in progress
//   done_out          out  one-cycle pulse at batch completion
//   sample_count_out  out  samples fully processed in the current batch
//
// Every output is a register updated together with the state, so each
// output reflects the state the FSM is in during that cycle.
// ---------------------------------------------------------------------------
module prop_sequencer
    import prop_seq_pkg::*;
#(
    parameter int LAYERS    = 4,
    parameter int SAMPLES_W = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 train_in,
    input  logic [SAMPLES_W-1:0] num_samples_in,
    input  logic                 abort_in,
    input  logic                 sample_valid_in,
    output logic                 sample_ready_out,
    output logic [LAYERS-1:0]    fd_prop_out,
    output logic [LAYERS-1:0]    bk_prop_out,
    output logic                 oscillator_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [SAMPLES_W-1:0] sample_count_out
);

    localparam int               IDX_W    = idx_width(LAYERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYERS - 1);

    seq_state_t           state;
    logic [IDX_W-1:0]     idx;
    logic                 train_q;
    logic [SAMPLES_W-1:0] num_q;
    logic [SAMPLES_W-1:0] count_inc;

    // count < N always holds while a sample is in flight, so the increment
    // can never wrap inside a batch.
    assign count_inc = sample_count_out + SAMPLES_W'(1);

    function automatic logic [LAYERS-1:0] strobe(input logic [IDX_W-1:0] k);
        return LAYERS'(1) << k;
    endfunction

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples the values from before this clock edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            idx              <= '0;
            train_q          <= 1'b0;
            num_q            <= '0;
            sample_ready_out <= 1'b0;
            fd_prop_out      <= '0;
            bk_prop_out      <= '0;
            oscillator_out   <= 1'b0;
            busy_out         <= 1'b0;
            done_out         <= 1'b0;
            sample_count_out <= '0;
        end else begin
            // Strobes, ready and done are single-cycle unless the branch
            // below re-asserts them for the state being entered.
            fd_prop_out      <= '0;
            bk_prop_out      <= '0;
            done_out         <= 1'b0;
            sample_ready_out <= 1'b0;

            if (state != IDLE && abort_in) begin
                // Abort wins over every other transition; count and
                // oscillator phase are left as they are.
                state    <= IDLE;
                idx      <= '0;
                busy_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_in) begin
                            busy_out         <= 1'b1;
                            train_q          <= train_in;
                            num_q            <= num_samples_in;
                            sample_count_out <= '0;
                            oscillator_out   <= 1'b0;
                            if (num_samples_in != '0) begin
                                state            <= WAIT_SAMPLE;
                                sample_ready_out <= 1'b1;
                            end else begin
                                state    <= DONE;
                                done_out <= 1'b1;
                            end
                        end
                    end

                    WAIT_SAMPLE: begin
                        // ready is high throughout this state, so valid
                        // alone completes the handshake.
                        if (sample_valid_in) begin
                            state       <= FWD;
                            idx         <= '0;
                            fd_prop_out <= strobe('0);
                        end else begin
                            sample_ready_out <= 1'b1;
                        end
                    end

                    FWD: begin
                        if (idx == LAST_IDX) begin
                            if (train_q) begin
                                state       <= BWD;
                                bk_prop_out <= strobe(LAST_IDX);
                            end else begin
                                state <= NEXT;
                            end
                        end else begin
                            idx         <= idx + IDX_W'(1);
                            fd_prop_out <= strobe(idx + IDX_W'(1));
                        end
                    end

                    BWD: begin
                        if (idx == '0) begin
                            state <= NEXT;
                        end else begin
                            idx         <= idx - IDX_W'(1);
                            bk_prop_out <= strobe(idx - IDX_W'(1));
                        end
                    end

                    NEXT: begin
                        sample_count_out <= count_inc;
                        oscillator_out   <= ~oscillator_out;
                        if (count_inc == num_q) begin
                            state    <= DONE;
                            done_out <= 1'b1;
                        end else begin
                            state            <= WAIT_SAMPLE;
                            sample_ready_out <= 1'b1;
                        end
                    end

                    DONE: begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end

                    default: begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prop_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prop_sequencer
//   Self-checking bench for prop_sequencer (LAYERS=4, SAMPLES_W=16).
//   The reference model tracks the batch at the level of the timing rules:
//   the edge at which each sample was transferred, the number of samples
//   completed and the oscillator phase. Expected strobes are derived from the
//   distance (in clock edges) to the transfer edge.
// ---------------------------------------------------------------------------
module tb_prop_sequencer;

    localparam int L  = 4;
    localparam int SW = 16;
    localparam int VW = 1 + L + L + 1 + 1 + 1 + SW;

    logic          clk_in          = 1'b0;
    logic          rst_in          = 1'b0;
    logic          start_in        = 1'b0;
    logic          train_in        = 1'b0;
    logic [SW-1:0] num_samples_in  = '0;
    logic          abort_in        = 1'b0;
    logic          sample_valid_in = 1'b0;
    logic          sample_ready_out;
    logic [L-1:0]  fd_prop_out;
    logic [L-1:0]  bk_prop_out;
    logic          oscillator_out;
    logic          busy_out;
    logic          done_out;
    logic [SW-1:0] sample_count_out;

    prop_sequencer #(.LAYERS(L), .SAMPLES_W(SW)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .start_in         (start_in),
        .train_in         (train_in),
        .num_samples_in   (num_samples_in),
        .abort_in         (abort_in),
        .sample_valid_in  (sample_valid_in),
        .sample_ready_out (sample_ready_out),
        .fd_prop_out      (fd_prop_out),
        .bk_prop_out      (bk_prop_out),
        .oscillator_out   (oscillator_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .sample_count_out (sample_count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    int          e           = 0;   // clock edges since time zero
    bit          m_busy      = 0;
    bit          m_train     = 0;
    bit          m_ready     = 0;
    bit          m_osc       = 0;
    int          m_n         = 0;
    int          m_count     = 0;
    int          m_xfer      = -1;  // edge of the in-flight sample's transfer
    int          m_done_edge = -2;  // edge after which done is shown
    logic [VW-1:0] m_vec     = '0;

    function automatic logic [VW-1:0] dut_vec();
        return {sample_ready_out, fd_prop_out, bk_prop_out, oscillator_out,
                busy_out, done_out, sample_count_out};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_train = 0; m_ready = 0; m_osc = 0;
        m_n = 0; m_count = 0; m_xfer = -1; m_done_edge = -2;
        m_vec = '0;
    endtask

    task automatic model_edge(input bit st, input bit tr, input bit ab,
                              input bit va, input int n);
        int len, d;
        logic [L-1:0] fd, bk;
        e++;
        len = m_train ? 2 * L : L;
        if (m_busy && ab) begin
            m_busy = 0; m_ready = 0; m_xfer = -1; m_done_edge = -2;
        end else if (m_busy && m_done_edge == e - 1) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_train = tr; m_n = n; m_count = 0; m_osc = 0; m_xfer = -1;
                if (n == 0) m_done_edge = e;
                else        m_ready = 1;
            end
        end else if (m_ready) begin
            if (va) begin
                m_xfer = e; m_ready = 0;
            end
        end else if (m_xfer >= 0 && e == m_xfer + len + 1) begin
            m_count++; m_osc = !m_osc; m_xfer = -1;
            if (m_count == m_n) m_done_edge = e;
            else                m_ready = 1;
        end
        fd = '0; bk = '0;
        if (m_xfer >= 0) begin
            d = e - m_xfer;
            if (d < L)                     fd = L'(1) << d;
            else if (m_train && d < 2 * L) bk = L'(1) << (2 * L - 1 - d);
        end
        m_vec = {m_ready, fd, bk, m_osc, m_busy, (m_done_edge == e), SW'(m_count)};
    endtask

    // Advance one clock: the model sees the inputs the DUT samples at the
    // edge, and outputs are observed 1 ns after it.
    task automatic step();
        bit st, tr, ab, va;
        int n;
        st = start_in; tr = train_in; ab = abort_in; va = sample_valid_in;
        n = int'(num_samples_in);
        @(posedge clk_in);
        model_edge(st, tr, ab, va, n);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_in = 1'b0;
        #12;
        n_checks++;
        if (dut_vec() !== '0) $display("FAIL reset_outputs: got %h expected %h", dut_vec(), '0);
        else n_pass++;
        @(negedge clk_in);
        rst_in = 1'b1;
        model_reset();
        repeat (3) begin
            step();
            n_checks++;
            if (dut_vec() !== m_vec) $display("FAIL reset_idle e=%0d: got %h expected %h", e, dut_vec(), m_vec);
            else n_pass++;
        end
    endtask

    task automatic test_train_two();
        logic [7:0] got[$];
        logic [7:0] want[$];
        int  dones = 0, xfer = -1, rdy_cycle = -1, osc_changes = 0, cyc = 0, bad = -1;
        bit  prev_osc = 0;
        num_samples_in = 2; train_in = 1; start_in = 1; sample_valid_in = 1;
        step();
        start_in = 0;
        n_checks++;
        if (dut_vec() !== m_vec) $display("FAIL train_start: got %h expected %h", dut_vec(), m_vec);
        else n_pass++;
        while (!(dones > 0 && !busy_out) && cyc < 80) begin
            if (sample_ready_out && sample_valid_in && xfer < 0) xfer = e + 1;
            step();
            cyc++;
            n_checks++;
            if (dut_vec() !== m_vec) $display("FAIL train_cycle e=%0d: got %h expected %h", e, dut_vec(), m_vec);
            else n_pass++;
            if ({bk_prop_out, fd_prop_out} != '0) got.push_back({bk_prop_out, fd_prop_out});
            if (oscillator_out !== prev_osc) begin osc_changes++; prev_osc = oscillator_out; end
            if (done_out) dones++;
            if (xfer >= 0 && rdy_cycle < 0 && sample_ready_out) rdy_cycle = e + 1;
        end
        sample_valid_in = 0;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < L; k++) want.push_back(8'(1) << k);
            for (int j = 0; j < L; j++) want.push_back(8'(1) << (L + L - 1 - j));
        end
        if (got.size() != want.size()) bad = 0;
        else for (int i = 0; i < want.size(); i++) if (bad < 0 && got[i] !== want[i]) bad = i;
        n_checks++;
        if (cyc >= 80) $display("FAIL train_timeout: ran %0d cycles without finishing", cyc);
        else n_pass++;
        n_checks++;
        if (bad >= 0) $display("FAIL train_strobe_order: %0d strobes seen, first bad index %0d (got %h expected %h)",
                               got.size(), bad, (bad < got.size()) ? got[bad] : 8'h0, want[bad]);
        else n_pass++;
        n_checks++;
        if (dones != 1) $display("FAIL train_done_pulses: got %0d expected 1", dones);
        else n_pass++;
        n_checks++;
        if (sample_count_out !== SW'(2)) $display("FAIL train_count: got %0d expected 2", sample_count_out);
        else n_pass++;
        n_checks++;
        if (osc_changes != 2 || oscillator_out !== 1'b0)
            $display("FAIL train_osc: got %0d toggles final %b expected 2 toggles final 0", osc_changes, oscillator_out);
        else n_pass++;
        n_checks++;
        if (rdy_cycle - xfer != 2 + 2 * L)
            $display("FAIL train_ready_latency: got %0d expected %0d", rdy_cycle - xfer, 2 + 2 * L);
        else n_pass++;
    endtask

    task automatic test_inference();
        int dones = 0, bk_cycles = 0, sweeps = 0, fd_cycles = 0, gap = -1, cyc = 0;
        num_samples_in = 3; train_in = 0; start_in = 1; sample_valid_in = 0;
        step();
        start_in = 0;
        n_checks++;
        if (dut_vec() !== m_vec) $display("FAIL infer_start: got %h expected %h", dut_vec(), m_vec);
        else n_pass++;
        while (!(dones > 0 && !busy_out) && cyc < 200) begin
            if (sample_ready_out) begin
                if (gap < 0) gap = int'($urandom_range(0, 5));
                sample_valid_in = (gap == 0);
                if (gap > 0) gap--; else gap = -1;
            end else begin
                sample_valid_in = 0;
            end
            step();
            cyc++;
            n_checks++;
            if (dut_vec() !== m_vec) $display("FAIL infer_cycle e=%0d: got %h expected %h", e, dut_vec(), m_vec);
            else n_pass++;
            if (bk_prop_out != '0) bk_cycles++;
            if (fd_prop_out != '0) fd_cycles++;
            if (fd_prop_out == L'(1)) sweeps++;
            if (done_out) dones++;
        end
        sample_valid_in = 0;
        n_checks++;
        if (cyc >= 200) $display("FAIL infer_timeout: ran %0d cycles without finishing", cyc);
        else n_pass++;
        n_checks++;
        if (bk_cycles != 0) $display("FAIL infer_no_bk: got %0d bk cycles expected 0", bk_cycles);
        else n_pass++;
        n_checks++;
        if (sweeps != 3 || fd_cycles != 3 * L)
            $display("FAIL infer_sweeps: got %0d sweeps %0d fd cycles expected 3 and %0d", sweeps, fd_cycles, 3 * L);
        else n_pass++;
        n_checks++;
        if (dones != 1 || sample_count_out !== SW'(3))
            $display("FAIL infer_done_count: got %0d dones count %0d expected 1 and 3", dones, sample_count_out);
        else n_pass++;
    endtask

    task automatic test_zero();
        int dones = 0, strobes = 0;
        num_samples_in = 0; train_in = 1'($urandom_range(0, 1)); start_in = 1;
        // start is presented in one cycle; done is visible in the next one.
        step();
        start_in = 0;
        n_checks++;
        if (done_out !== 1'b1 || busy_out !== 1'b1)
            $display("FAIL zero_done_timing: got done %b busy %b expected 1 1", done_out, busy_out);
        else n_pass++;
        if (done_out) dones++;
        repeat (4) begin
            step();
            n_checks++;
            if (dut_vec() !== m_vec) $display("FAIL zero_cycle e=%0d: got %h expected %h", e, dut_vec(), m_vec);
            else n_pass++;
            if (done_out) dones++;
            if ({fd_prop_out, bk_prop_out} != '0) strobes++;
        end
        n_checks++;
        if (dones != 1 || strobes != 0 || sample_count_out !== '0 || oscillator_out !== 1'b0 || busy_out !== 1'b0)
            $display("FAIL zero_summary: got dones %0d strobes %0d count %0d osc %b busy %b expected 1 0 0 0 0",
                     dones, strobes, sample_count_out, oscillator_out, busy_out);
        else n_pass++;
    endtask

    task automatic test_abort();
        int cyc = 0, dones = 0;
        num_samples_in = 5; train_in = 1; start_in = 1; sample_valid_in = 1;
        step();
        start_in = 0;
        while (bk_prop_out != 4'b0100 && cyc < 40) begin
            step();
            cyc++;
            n_checks++;
            if (dut_vec() !== m_vec) $display("FAIL abort_run e=%0d: got %h expected %h", e, dut_vec(), m_vec);
            else n_pass++;
        end
        n_checks++;
        if (cyc >= 40) $display("FAIL abort_reach_bwd: bk strobe 0100 not seen in %0d cycles", cyc);
        else n_pass++;
        abort_in = 1;
        step();
        abort_in = 0;
        n_checks++;
        if ({fd_prop_out, bk_prop_out} !== '0 || busy_out !== 1'b0 || done_out !== 1'b0 || sample_count_out !== '0)
            $display("FAIL abort_effect: got fd %b bk %b busy %b done %b count %0d expected all 0",
                     fd_prop_out, bk_prop_out, busy_out, done_out, sample_count_out);
        else n_pass++;
        repeat (5) begin
            step();
            n_checks++;
            if (dut_vec() !== m_vec) $display("FAIL abort_after e=%0d: got %h expected %h", e, dut_vec(), m_vec);
            else n_pass++;
            if (done_out) dones++;
        end
        n_checks++;
        if (dones != 0) $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
        else n_pass++;
        // restart with a single-sample batch
        num_samples_in = 1; start_in = 1;
        step();
        start_in = 0;
        cyc = 0;
        while (!(dones > 0 && !busy_out) && cyc < 40) begin
            step();
            cyc++;
            n_checks++;
            if (dut_vec() !== m_vec) $display("FAIL abort_restart e=%0d: got %h expected %h", e, dut_vec(), m_vec);
            else n_pass++;
            if (done_out) dones++;
        end
        sample_valid_in = 0;
        n_checks++;
        if (dones != 1 || sample_count_out !== SW'(1))
            $display("FAIL abort_restart_done: got %0d dones count %0d expected 1 and 1", dones, sample_count_out);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int cyc = 0;
        num_samples_in = 2; train_in = 1; start_in = 1; sample_valid_in = 1;
        step();
        start_in = 0;
        while (fd_prop_out != 4'b0010 && cyc < 20) begin
            step();
            cyc++;
        end
        n_checks++;
        if (cyc >= 20) $display("FAIL areset_reach_fwd: fd strobe 0010 not seen in %0d cycles", cyc);
        else n_pass++;
        #3;
        rst_in = 0;
        #1;
        n_checks++;
        if (dut_vec() !== '0) $display("FAIL areset_immediate: got %h expected %h", dut_vec(), '0);
        else n_pass++;
        model_reset();
        sample_valid_in = 0;
        @(negedge clk_in);
        rst_in = 1;
        repeat (3) begin
            step();
            n_checks++;
            if (dut_vec() !== m_vec) $display("FAIL areset_idle e=%0d: got %h expected %h", e, dut_vec(), m_vec);
            else n_pass++;
        end
    endtask

    task automatic test_busy_start();
        int cyc = 0, dones = 0, fd_cycles = 0, bk_cycles = 0;
        num_samples_in = 2; train_in = 1; start_in = 1; sample_valid_in = 1;
        step();
        start_in = 0;
        repeat (3) step();
        num_samples_in = 9; train_in = 0; start_in = 1;
        step();
        start_in = 0;
        if (fd_prop_out != '0) fd_cycles++;
        while (!(dones > 0 && !busy_out) && cyc < 80) begin
            step();
            cyc++;
            n_checks++;
            if (dut_vec() !== m_vec) $display("FAIL busy_start_cycle e=%0d: got %h expected %h", e, dut_vec(), m_vec);
            else n_pass++;
            if (fd_prop_out != '0) fd_cycles++;
            if (bk_prop_out != '0) bk_cycles++;
            if (done_out) dones++;
        end
        sample_valid_in = 0;
        n_checks++;
        if (dones != 1 || sample_count_out !== SW'(2))
            $display("FAIL busy_start_count: got %0d dones count %0d expected 1 and 2", dones, sample_count_out);
        else n_pass++;
        // The fd count misses the strobes before the ignored start; bk is complete.
        n_checks++;
        if (bk_cycles != 2 * L) $display("FAIL busy_start_mode: got %0d bk cycles expected %0d", bk_cycles, 2 * L);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int b = 0; b < 4; b++) begin
            int cyc = 0;
            num_samples_in = SW'($urandom_range(1, 4));
            train_in = 1'($urandom_range(0, 1));
            start_in = 1;
            step();
            start_in = 0;
            while (busy_out && cyc < 200) begin
                sample_valid_in = ($urandom_range(0, 2) != 0);
                abort_in = ($urandom_range(0, 59) == 0);
                step();
                abort_in = 0;
                cyc++;
                n_checks++;
                if (dut_vec() !== m_vec) $display("FAIL random_cycle b=%0d e=%0d: got %h expected %h", b, e, dut_vec(), m_vec);
                else n_pass++;
            end
            sample_valid_in = 0;
            n_checks++;
            if (cyc >= 200) $display("FAIL random_timeout: batch %0d still busy after %0d cycles", b, cyc);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_train_two();
        test_inference();
        test_zero();
        test_abort();
        test_async_reset();
        test_busy_start();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
